// File: rtl/vector_compute_engine.sv
// Vector engine: dot product, sum or max over programmable-length vectors in a
// shared single-port memory, with controller writes taking priority on the port.
module vector_compute_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned ACC_W   = 2 * DATA_W + LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              err,
    input  logic [ADDR_W-1:0] ctrl_addr,
    input  logic              ctrl_wr,
    input  logic [DATA_W-1:0] ctrl_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_A, WT_A, RD_B, WT_B, DONE} state_t;

    localparam logic [1:0]       MODE_DOT  = 2'd0;
    localparam logic [1:0]       MODE_SUM  = 2'd1;
    localparam logic [1:0]       MODE_RSVD = 2'd3;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [ACC_W-1:0] OVF_LIMIT = ACC_W'((64'd1 << OUT_W) - 64'd1);

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   base_a_q, base_a_d;
    logic [ADDR_W-1:0]   base_b_q, base_b_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic                err_d;
    logic                last;
    logic [ACC_W-1:0]    rdata_ext;
    logic [ADDR_W-1:0]   eng_addr;

    assign last      = (idx_q == len_q - LEN_W'(1));
    assign rdata_ext = ACC_W'(mem_rdata);
    assign eng_addr  = ((state_q == RD_B) ? base_b_q : base_a_q) + ADDR_W'(idx_q);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        len_d    = len_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        a_d      = a_q;
        err_d    = err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (mode == MODE_RSVD || len > MAX_LEN_V) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len == '0) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        err_d    = 1'b0;
                        mode_d   = mode;
                        base_a_d = base_a;
                        base_b_d = base_b;
                        len_d    = len;
                        idx_d    = '0;
                        state_d  = RD_A;
                    end
                end
            end
            RD_A: if (!ctrl_wr) state_d = WT_A;
            WT_A: begin
                if (mode_q == MODE_DOT) begin
                    a_d     = mem_rdata;
                    state_d = RD_B;
                end else begin
                    if (mode_q == MODE_SUM) begin
                        acc_d = acc_q + rdata_ext;
                    end else if (rdata_ext > acc_q) begin
                        acc_d = rdata_ext;
                    end
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = last ? DONE : RD_A;
                end
            end
            RD_B: if (!ctrl_wr) state_d = WT_B;
            WT_B: begin
                acc_d   = acc_q + ACC_W'(a_q) * rdata_ext;
                idx_d   = idx_q + LEN_W'(1);
                state_d = last ? DONE : RD_A;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared memory port: controller writes win over engine reads
    always_comb begin
        mem_wdata = ctrl_wdata;
        mem_addr  = ctrl_addr;
        mem_wr    = 1'b0;
        if (ctrl_wr) begin
            mem_wr = 1'b1;
        end else if (state_q == RD_A || state_q == RD_B) begin
            mem_addr = eng_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            err      <= err_d;
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            // Result and flag are loaded on entry to DONE so they line up with done
            if (state_d == DONE) begin
                result   <= acc_d;
                overflow <= (acc_d > OVF_LIMIT);
            end
        end
    end

endmodule

// File: tb/tb_vector_compute_engine.sv
// Self-checking bench for vector_compute_engine: memory model, scoreboard of
// expected completions and per-scenario tasks.
module tb_vector_compute_engine;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;
    localparam int ACC_W  = 2 * DATA_W + LEN_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              overflow;
    logic              err;
    logic [ADDR_W-1:0] ctrl_addr;
    logic              ctrl_wr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    vector_compute_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .base_a    (base_a),
        .base_b    (base_b),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .err       (err),
        .ctrl_addr (ctrl_addr),
        .ctrl_wr   (ctrl_wr),
        .ctrl_wdata(ctrl_wdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with registered read
    logic [DATA_W-1:0] tb_mem [16];
    logic [DATA_W-1:0] shadow [16];
    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             ovf;
        logic             er;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [ACC_W-1:0] model(input logic [1:0] m, input logic [3:0] ba,
                                               input logic [3:0] bb, input int n);
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] a;
        logic [ACC_W-1:0] b;
        acc = '0;
        if (m == 2'd3 || n > 8) return '0;
        for (int i = 0; i < n; i++) begin
            a = ACC_W'(shadow[ba + 4'(i)]);
            b = ACC_W'(shadow[bb + 4'(i)]);
            if (m == 2'd0) acc = acc + a * b;
            else if (m == 2'd1) acc = acc + a;
            else if (a > acc) acc = a;
        end
        return acc;
    endfunction

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ctrl_addr  = a;
        ctrl_wdata = d;
        ctrl_wr    = 1'b1;
        shadow[a]  = d;
        @(negedge clk);
        ctrl_wr = 1'b0;
    endtask

    // Drives a one-cycle start and queues the expected completion
    task automatic start_op(input logic [1:0] m, input logic [3:0] ba, input logic [3:0] bb,
                            input int n, input int stall, output int t);
        exp_t e;
        int   lat;
        @(negedge clk);
        mode   = m;
        base_a = ba;
        base_b = bb;
        len    = LEN_W'(n);
        start  = 1'b1;
        t      = cyc;
        e.er   = (m == 2'd3) || (n > 8);
        e.res  = model(m, ba, bb, n);
        e.ovf  = (e.res > 20'd255);
        if (e.er || n == 0) lat = 1;
        else if (m == 2'd0) lat = 4 * n + 1;
        else lat = 2 * n + 1;
        e.cyc = t + lat + stall;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
                end else begin
                    e = sb.pop_front();
                    tests++;
                    if (result !== e.res) begin
                        fails++;
                        $display("FAIL result: got %0d expected %0d", result, e.res);
                    end
                    tests++;
                    if (overflow !== e.ovf) begin
                        fails++;
                        $display("FAIL overflow: got %b expected %b", overflow, e.ovf);
                    end
                    tests++;
                    if (err !== e.er) begin
                        fails++;
                        $display("FAIL err: got %b expected %b", err, e.er);
                    end
                    tests++;
                    if (cyc != e.cyc) begin
                        fails++;
                        $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d completions still pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        ctrl_addr = 4'd7;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (result !== '0)     begin fails++; $display("FAIL reset_result: got %0d expected 0", result); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests++; if (err !== 1'b0)      begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        tests++; if (mem_wr !== 1'b0 || mem_addr !== 4'd7) begin
            fails++; $display("FAIL reset_mux: got wr=%b addr=%0d expected wr=0 addr=7", mem_wr, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dot();
        int t;
        for (int i = 0; i < 4; i++) begin
            write_mem(4'(i), 8'(i + 1));
            write_mem(4'(i + 8), 8'(i + 5));
        end
        start_op(2'd0, 4'd0, 4'd8, 4, 0, t);
        wait_drain(60);
    endtask

    task automatic test_sum_max();
        int t;
        start_op(2'd1, 4'd0, 4'd0, 4, 0, t);
        wait_drain(40);
        write_mem(4'd0, 8'd3);
        write_mem(4'd1, 8'd200);
        write_mem(4'd2, 8'd7);
        write_mem(4'd3, 8'd9);
        start_op(2'd2, 4'd0, 4'd0, 4, 0, t);
        wait_drain(40);
    endtask

    task automatic test_overflow();
        int t;
        for (int i = 0; i < 16; i++) write_mem(4'(i), 8'd255);
        start_op(2'd0, 4'd0, 4'd8, 8, 0, t);
        wait_drain(60);
    endtask

    task automatic test_stall();
        int t;
        for (int i = 0; i < 4; i++) begin
            write_mem(4'(i), 8'(i + 1));
            write_mem(4'(i + 8), 8'(i + 5));
        end
        start_op(2'd0, 4'd0, 4'd8, 4, 3, t);
        repeat (2) @(negedge clk);
        // First RD_B cycle of the first element
        for (int i = 0; i < 3; i++) begin
            ctrl_addr  = 4'd15;
            ctrl_wdata = 8'h5A;
            ctrl_wr    = 1'b1;
            shadow[15] = 8'h5A;
            #1;
            tests++;
            if (mem_addr !== 4'd15 || mem_wr !== 1'b1) begin
                fails++;
                $display("FAIL stall_mux: got addr=%0d wr=%b expected addr=15 wr=1", mem_addr, mem_wr);
            end
            @(negedge clk);
        end
        ctrl_wr = 1'b0;
        wait_drain(60);
        tests++;
        if (tb_mem[15] !== 8'h5A) begin
            fails++;
            $display("FAIL stall_write: got %h expected 5a", tb_mem[15]);
        end
    endtask

    task automatic test_errors();
        int t;
        start_op(2'd3, 4'd0, 4'd8, 4, 0, t);
        wait_drain(10);
        start_op(2'd0, 4'd0, 4'd8, 9, 0, t);
        wait_drain(10);
        start_op(2'd0, 4'd0, 4'd8, 0, 0, t);
        wait_drain(10);
    endtask

    task automatic test_wrap();
        int t;
        logic [3:0] ea;
        write_mem(4'd14, 8'd10);
        write_mem(4'd15, 8'd20);
        write_mem(4'd0, 8'd30);
        write_mem(4'd1, 8'd40);
        ctrl_addr = 4'd5;
        start_op(2'd1, 4'd14, 4'd0, 4, 0, t);
        for (int i = 0; i < 4; i++) begin
            ea = 4'd14 + 4'(i);
            tests++;
            if (mem_addr !== ea || mem_wr !== 1'b0) begin
                fails++;
                $display("FAIL wrap_addr: got addr=%0d wr=%b expected addr=%0d wr=0", mem_addr, mem_wr, ea);
            end
            repeat (2) @(negedge clk);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid();
        int t;
        start_op(2'd0, 4'd0, 4'd8, 4, 0, t);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0)   begin fails++; $display("FAIL midreset_done: got %b expected 0", done); end
        tests++; if (result !== '0)   begin fails++; $display("FAIL midreset_result: got %0d expected 0", result); end
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL midreset_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int t;
        int t2;
        write_mem(4'd0, 8'd4);
        write_mem(4'd1, 8'd9);
        write_mem(4'd2, 8'd2);
        write_mem(4'd3, 8'd6);
        start_op(2'd1, 4'd0, 4'd0, 4, 0, t);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL busy_during_op: got %b expected 1", busy);
        end
        // Start while busy must be ignored
        mode  = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'd0;
        repeat (6) @(negedge clk);
        start_op(2'd2, 4'd0, 4'd0, 4, 0, t2);
        tests++;
        if (t2 != t + 10) begin
            fails++; $display("FAIL b2b_slot: got start cycle %0d expected %0d", t2, t + 10);
        end
        wait_drain(40);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        mode       = 2'd0;
        base_a     = '0;
        base_b     = '0;
        len        = '0;
        ctrl_addr  = '0;
        ctrl_wr    = 1'b0;
        ctrl_wdata = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_dot();
        test_sum_max();
        test_overflow();
        test_stall();
        test_errors();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
